// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: op codes, instruction layout and data width.
package alu_pkg;

  localparam int DW   = 16;
  localparam int NREG = 16;
  localparam int AW   = 4;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 4;
  localparam int RT_HI  = 3;
  localparam int RT_LO  = 0;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SLL = 3'd4,
    OP_SRL = 3'd5,
    OP_SRA = 3'd6,
    OP_ROL = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
  } instr_t;

  // Shift-class ops take their rt field as an immediate amount.
  function automatic logic op_is_shift(input alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/issue_regfile.sv
// 2-read/1-write register file with r0 hardwired to zero and write-back bypass.
module issue_regfile #(
  parameter int DW   = 16,
  parameter int NREG = 16,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr_a,
  output logic [DW-1:0] rd_data_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_b
);

  logic [DW-1:0] regs_r [NREG-1:1];

  // Register storage; r0 has no storage so writes to it vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        regs_r[i] <= {DW{1'b0}};
      end
    end else if (wr_en && (wr_addr != {AW{1'b0}})) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Read port A with same-cycle bypass of the incoming write-back.
  always_comb begin
    rd_data_a = {DW{1'b0}};
    if (rd_addr_a == {AW{1'b0}}) begin
      rd_data_a = {DW{1'b0}};
    end else if (wr_en && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = regs_r[rd_addr_a];
    end
  end

  // Read port B with same-cycle bypass of the incoming write-back.
  always_comb begin
    rd_data_b = {DW{1'b0}};
    if (rd_addr_b == {AW{1'b0}}) begin
      rd_data_b = {DW{1'b0}};
    end else if (wr_en && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = regs_r[rd_addr_b];
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode, scoreboard and operand-issue stage feeding the 16-bit ALU.
// Optional ISSUE_PERF_EN adds saturating issue/stall counters.
module alu_issue_stage #(
  parameter int DW   = 16,
  parameter int NREG = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [2:0]    out_op,
  output logic [3:0]    out_imm,
  output logic [3:0]    out_rd,
  input  logic          wb_en,
  input  logic [3:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          illegal
`ifdef ISSUE_PERF_EN
  ,
  output logic [15:0]   perf_issued,
  output logic [15:0]   perf_stall
`endif
);

  import alu_pkg::*;

  instr_t        instr_s;
  alu_op_e       op_s;
  logic          is_illegal_s;
  logic          is_shift_s;
  logic [DW-1:0] read_a_s;
  logic [DW-1:0] read_b_s;
  logic          rs_blk_s;
  logic          rt_blk_s;
  logic          rd_blk_s;
  logic          hazard_s;
  logic          slot_free_s;
  logic          accept_s;
  logic          issue_s;
  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_next_s;

  logic          out_valid_r;
  logic [DW-1:0] out_a_r;
  logic [DW-1:0] out_b_r;
  logic [2:0]    out_op_r;
  logic [3:0]    out_imm_r;
  logic [3:0]    out_rd_r;
  logic          illegal_r;

  assign instr_s = '{opcode: in_instr[OPC_HI:OPC_LO],
                     rd:     in_instr[RD_HI:RD_LO],
                     rs:     in_instr[RS_HI:RS_LO],
                     rt:     in_instr[RT_HI:RT_LO]};

  assign op_s         = alu_op_e'(instr_s.opcode[2:0]);
  assign is_illegal_s = instr_s.opcode[3];
  assign is_shift_s   = op_is_shift(op_s);

  issue_regfile #(.DW(DW), .NREG(NREG), .AW(4)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .rd_addr_a (instr_s.rs),
    .rd_data_a (read_a_s),
    .rd_addr_b (instr_s.rt),
    .rd_data_b (read_b_s)
  );

  // Hazard detection: a busy register is released early by this cycle's write-back.
  always_comb begin
    rs_blk_s = busy_r[instr_s.rs] && !(wb_en && (wb_addr == instr_s.rs));
    rt_blk_s = busy_r[instr_s.rt] && !(wb_en && (wb_addr == instr_s.rt));
    rd_blk_s = busy_r[instr_s.rd] && !(wb_en && (wb_addr == instr_s.rd));
    if (is_illegal_s) begin
      hazard_s = 1'b0;
    end else begin
      hazard_s = rs_blk_s || (!is_shift_s && rt_blk_s) || rd_blk_s;
    end
  end

  assign slot_free_s = !out_valid_r || out_ready;
  assign in_ready    = slot_free_s && !hazard_s;
  assign accept_s    = in_valid && in_ready;
  assign issue_s     = accept_s && !is_illegal_s;

  // Scoreboard update: write-back clears first so a same-cycle issue set wins.
  always_comb begin
    busy_next_s = busy_r;
    if (wb_en) begin
      busy_next_s[wb_addr] = 1'b0;
    end else begin
      busy_next_s = busy_r;
    end
    if (issue_s && (instr_s.rd != 4'd0)) begin
      busy_next_s[instr_s.rd] = 1'b1;
    end else begin
      busy_next_s[0] = 1'b0;
    end
    busy_next_s[0] = 1'b0;
  end

  // Output register and scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_a_r     <= {DW{1'b0}};
      out_b_r     <= {DW{1'b0}};
      out_op_r    <= 3'd0;
      out_imm_r   <= 4'd0;
      out_rd_r    <= 4'd0;
      illegal_r   <= 1'b0;
      busy_r      <= {NREG{1'b0}};
    end else begin
      illegal_r <= accept_s && is_illegal_s;
      busy_r    <= busy_next_s;
      if (issue_s) begin
        out_valid_r <= 1'b1;
        out_a_r     <= read_a_s;
        out_b_r     <= is_shift_s ? {DW{1'b0}} : read_b_s;
        out_op_r    <= op_s;
        out_imm_r   <= is_shift_s ? instr_s.rt : 4'd0;
        out_rd_r    <= instr_s.rd;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_a     = out_a_r;
  assign out_b     = out_b_r;
  assign out_op    = out_op_r;
  assign out_imm   = out_imm_r;
  assign out_rd    = out_rd_r;
  assign illegal   = illegal_r;

`ifdef ISSUE_PERF_EN
  logic [15:0] perf_issued_r;
  logic [15:0] perf_stall_r;
  logic        stall_s;

  assign stall_s = in_valid && slot_free_s && hazard_s;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_r <= 16'd0;
      perf_stall_r  <= 16'd0;
    end else begin
      if (issue_s && (perf_issued_r != 16'hFFFF)) begin
        perf_issued_r <= perf_issued_r + 16'd1;
      end
      if (stall_s && (perf_stall_r != 16'hFFFF)) begin
        perf_stall_r <= perf_stall_r + 16'd1;
      end
    end
  end

  assign perf_issued = perf_issued_r;
  assign perf_stall  = perf_stall_r;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [2:0]  out_op;
  logic [3:0]  out_imm;
  logic [3:0]  out_rd;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_addr = 4'd0;
  logic [15:0] wb_data = 16'h0000;
  logic        illegal;
`ifdef ISSUE_PERF_EN
  logic [15:0] perf_issued;
  logic [15:0] perf_stall;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  alu_issue_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_op    (out_op),
    .out_imm   (out_imm),
    .out_rd    (out_rd),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .illegal   (illegal)
`ifdef ISSUE_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  wire [43:0] outs = {out_valid, out_a, out_b, out_op, out_imm, out_rd};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (outs !== 44'h0) $display("FAIL reset_outs got=%h want=%h", outs, 44'h0);
    else n_pass++;
    n_checks++;
    if ({illegal, in_ready} !== 2'b01) $display("FAIL reset_flags got=%b want=01", {illegal, in_ready});
    else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_issue;
    wb_en = 1'b1; wb_addr = 4'd1; wb_data = 16'd5;
    step();
    wb_addr = 4'd2; wb_data = 16'd3;
    step();
    wb_en = 1'b0;
    in_valid = 1'b1; in_instr = 16'h0312; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL add_ready got=%b want=1", in_ready);
    else n_pass++;
    step();
    n_checks++;
    if (outs !== {1'b1, 16'd5, 16'd3, 3'd0, 4'd0, 4'd3})
      $display("FAIL add_outs got=%h want=%h", outs, {1'b1, 16'd5, 16'd3, 3'd0, 4'd0, 4'd3});
    else n_pass++;
  endtask

  task automatic test_raw_bypass;
    in_instr = 16'h1431;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL raw_block1 got=%b want=0", in_ready);
    else n_pass++;
    step();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b00) $display("FAIL raw_block2 got=%b want=00", {out_valid, in_ready});
    else n_pass++;
    in_instr = 16'h0312;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL waw_block got=%b want=0", in_ready);
    else n_pass++;
    in_instr = 16'h1431; wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'd8;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL raw_release got=%b want=1", in_ready);
    else n_pass++;
    step();
    wb_en = 1'b0;
    n_checks++;
    if (outs !== {1'b1, 16'd8, 16'd5, 3'd1, 4'd0, 4'd4})
      $display("FAIL sub_outs got=%h want=%h", outs, {1'b1, 16'd8, 16'd5, 3'd1, 4'd0, 4'd4});
    else n_pass++;
  endtask

  task automatic test_shift;
    in_instr = 16'h0614;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL rt_block got=%b want=0", in_ready);
    else n_pass++;
    in_instr = 16'h4514;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL sll_ready got=%b want=1", in_ready);
    else n_pass++;
    step();
    n_checks++;
    if (outs !== {1'b1, 16'd5, 16'd0, 3'd4, 4'd4, 4'd5})
      $display("FAIL sll_outs got=%h want=%h", outs, {1'b1, 16'd5, 16'd0, 3'd4, 4'd4, 4'd5});
    else n_pass++;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0; in_instr = 16'h0712;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({in_ready, outs} !== {1'b0, 1'b1, 16'd5, 16'd0, 3'd4, 4'd4, 4'd5})
        $display("FAIL hold_%0d got=%h want=%h", i, {in_ready, outs}, {1'b0, 1'b1, 16'd5, 16'd0, 3'd4, 4'd4, 4'd5});
      else n_pass++;
      step();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL drain_ready got=%b want=1", in_ready);
    else n_pass++;
    step();
    n_checks++;
    if (outs !== {1'b1, 16'd5, 16'd3, 3'd0, 4'd0, 4'd7})
      $display("FAIL drain_outs got=%h want=%h", outs, {1'b1, 16'd5, 16'd3, 3'd0, 4'd0, 4'd7});
    else n_pass++;
  endtask

  task automatic test_illegal;
    in_instr = 16'h9123;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL ill_ready got=%b want=1", in_ready);
    else n_pass++;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({illegal, out_valid} !== 2'b10) $display("FAIL ill_pulse got=%b want=10", {illegal, out_valid});
    else n_pass++;
    step();
    in_instr = 16'h0810;
    #1;
    n_checks++;
    if ({illegal, in_ready} !== 2'b01) $display("FAIL ill_after got=%b want=01", {illegal, in_ready});
    else n_pass++;
    in_instr = 16'h9412; in_valid = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL ill_nohazard got=%b want=1", in_ready);
    else n_pass++;
    step();
    in_valid = 1'b0; in_instr = 16'h0640;
    #1;
    n_checks++;
    if ({illegal, out_valid, in_ready} !== 3'b100)
      $display("FAIL ill_busy_kept got=%b want=100", {illegal, out_valid, in_ready});
    else n_pass++;
  endtask

  task automatic test_r0;
    wb_en = 1'b1; wb_addr = 4'd0; wb_data = 16'h1234;
    in_instr = 16'h0600; in_valid = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL r0_ready got=%b want=1", in_ready);
    else n_pass++;
    step();
    wb_en = 1'b0;
    n_checks++;
    if (outs !== {1'b1, 16'd0, 16'd0, 3'd0, 4'd0, 4'd6})
      $display("FAIL r0_bypass got=%h want=%h", outs, {1'b1, 16'd0, 16'd0, 3'd0, 4'd0, 4'd6});
    else n_pass++;
    in_instr = 16'h0800;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (outs !== {1'b1, 16'd0, 16'd0, 3'd0, 4'd0, 4'd8})
      $display("FAIL r0_stored got=%h want=%h", outs, {1'b1, 16'd0, 16'd0, 3'd0, 4'd0, 4'd8});
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 16'h0077;
    step();
    wb_en = 1'b0;
    in_valid = 1'b1; in_instr = 16'h0950;
    step();
    n_checks++;
    if (outs !== {1'b1, 16'h0077, 16'd0, 3'd0, 4'd0, 4'd9})
      $display("FAIL b2b_clear got=%h want=%h", outs, {1'b1, 16'h0077, 16'd0, 3'd0, 4'd0, 4'd9});
    else n_pass++;
    in_instr = 16'h2A12; wb_en = 1'b1; wb_addr = 4'd10; wb_data = 16'hFFFF;
    step();
    wb_en = 1'b0;
    n_checks++;
    if (outs !== {1'b1, 16'd5, 16'd3, 3'd2, 4'd0, 4'd10})
      $display("FAIL b2b_and got=%h want=%h", outs, {1'b1, 16'd5, 16'd3, 3'd2, 4'd0, 4'd10});
    else n_pass++;
    in_instr = 16'h3B12;
    step();
    n_checks++;
    if (outs !== {1'b1, 16'd5, 16'd3, 3'd3, 4'd0, 4'd11})
      $display("FAIL b2b_or got=%h want=%h", outs, {1'b1, 16'd5, 16'd3, 3'd3, 4'd0, 4'd11});
    else n_pass++;
    in_instr = 16'h7D1F;
    step();
    n_checks++;
    if (outs !== {1'b1, 16'd5, 16'd0, 3'd7, 4'd15, 4'd13})
      $display("FAIL b2b_rol got=%h want=%h", outs, {1'b1, 16'd5, 16'd0, 3'd7, 4'd15, 4'd13});
    else n_pass++;
    in_valid = 1'b0; in_instr = 16'h0CA0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL set_wins got=%b want=0", in_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    in_valid = 1'b1; in_instr = 16'h0312; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL pre_rst_valid got=%b want=1", out_valid);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({outs, illegal} !== 45'h0) $display("FAIL async_rst got=%h want=0", {outs, illegal});
    else n_pass++;
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 16'h0D12;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL post_rst_ready got=%b want=1", in_ready);
    else n_pass++;
    step();
    n_checks++;
    if (outs !== {1'b1, 16'd0, 16'd0, 3'd0, 4'd0, 4'd13})
      $display("FAIL post_rst_regs got=%h want=%h", outs, {1'b1, 16'd0, 16'd0, 3'd0, 4'd0, 4'd13});
    else n_pass++;
    in_instr = 16'h0E34;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL post_rst_busy got=%b want=1", in_ready);
    else n_pass++;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (outs !== {1'b1, 16'd0, 16'd0, 3'd0, 4'd0, 4'd14})
      $display("FAIL post_rst_r3 got=%h want=%h", outs, {1'b1, 16'd0, 16'd0, 3'd0, 4'd0, 4'd14});
    else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_first_issue();
    test_raw_bypass();
    test_shift();
    test_backpressure();
    test_illegal();
    test_r0();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-issue stage directly upstream of the 16-bit ALU.
- Accepts 16-bit instruction words and decodes them.
- Reads operands from an internal 16x16 register file with write-back bypass.
- Blocks RAW/WAW hazards with a per-register busy scoreboard.
- Presents registered A, B, op and imm to the ALU behind a valid/ready handshake.
- The result write-back port returns from the ALU's consumer stage.

Parameters:
- DW, 16, data/register width
- NREG, 16, register count; index width 4

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word present
- in_ready  out  1  stage accepts instruction this cycle
- in_instr  in  16  [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt or imm
- out_valid  out  1  ALU operands valid
- out_ready  in  1  ALU side consumes this cycle
- out_a  out  DW  operand A (signed)
- out_b  out  DW  operand B (signed)
- out_op  out  3  ALU op code
- out_imm  out  4  shift/rotate amount
- out_rd  out  4  destination tag, travels with result
- wb_en  in  1  write-back strobe
- wb_addr  in  4  write-back register
- wb_data  in  DW  write-back value
- illegal  out  1  one-cycle pulse: illegal opcode dropped

Behaviour:
- Reset (async, rst_n=0):
  - All registers and busy bits cleared.
  - out_valid=0; out_a, out_b, out_op, out_imm, out_rd = 0; illegal=0.
- Decode:
  - opcode[3]=0: ALU op = opcode[2:0] (0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SRA, 7 ROL).
  - opcode[3]=1: illegal.
  - Ops 4-7 (shift): rt field is imm, out_b=0, rt not hazard-checked.
  - Ops 0-3: out_imm=0.
- Register file:
  - 2 combinational read ports, 1 write port on clk.
  - r0 reads 0; writes to r0 are ignored.
  - Write-back occurs whenever wb_en=1, independent of the handshake.
- Bypass: if wb_en and wb_addr==src and src!=0, the read returns wb_data in the same cycle.
- Scoreboard (busy[15:1]):
  - Set on issue of a legal instruction with rd!=0.
  - Cleared when wb_en to that address.
  - Issue-set and wb-clear of the same register in the same cycle: set wins.
- Hazard:
  - A source or rd is blocked if busy and not cleared by this cycle's wb (wb_en && wb_addr==reg).
  - Legal instruction hazard = rs blocked, or (op 0-3 and rt blocked), or rd blocked.
  - Illegal instructions ignore hazards.
- Handshake:
  - slot_free = !out_valid || out_ready.
  - in_ready = slot_free && !hazard.
  - Accept on in_valid && in_ready.
  - Legal accept: output register loads next edge, out_valid=1.
  - Illegal accept: dropped, illegal=1 for one cycle, out_valid falls if slot drained.
  - Output fields hold stable while out_valid && !out_ready.
  - Back-to-back issue at one instruction per cycle when no hazard.
- Latency: accept edge to out_valid = 1 cycle.
- Reset mid-operation: pending issue and busy bits are discarded; no write-back is replayed.

Optional Feature:
- ISSUE_PERF_EN defined:
  - Adds outputs perf_issued[15:0] (legal issues) and perf_stall[15:0] (cycles with in_valid && slot_free && hazard).
  - Both counters saturate at 16'hFFFF and reset to 0.
- ISSUE_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - Op-code constants OP_ADD..OP_ROL.
  - Instruction field positions.
  - Instruction struct typedef.
  - DW.
  - The ALU switches to these constants.
- One sub-module: issue_regfile (16x16, 2R1W, r0 hardwired, internal bypass).
- Scoreboard and handshake stay in the top module.

Test Plan:
- Reset, then wb r1=5, r2=3; issue ADD r3,r1,r2 (16'h0312) -> next cycle out_valid=1, out_a=5, out_b=3, out_op=0, out_rd=3; busy[3]=1.
- Issue SUB r4,r3,r1 while r3 busy -> in_ready=0 until wb_en r3=8; in the wb cycle bypass gives out_a=8, out_b=5, op=1.
- Issue SLL r5,r1,#4 (16'h4514) -> out_a=5, out_b=0, out_imm=4, op=4; rt=4 not checked while r4 busy.
- Hold out_ready=0 for 3 cycles with in_valid high -> outputs stable, in_ready=0; out_ready=1 -> next instruction issues same edge.
- Instr 16'h9123 -> illegal pulses 1 cycle, no out_valid, busy unchanged; write to r0 then ADD r6,r0,r0 -> out_a=0, out_b=0.
- Assert rst_n=0 with r3 busy and out_valid=1 -> immediate out_valid=0, busy=0, all registers read 0.
